// File: rtl/cla_carry_sequencer.sv
// Multi-cycle group carry-lookahead: resolves GROUP carries per clock for a WIDTH-bit PFA row.
// Optional overflow flag V built only when CLA_CARRY_SEQUENCER_OVF_EN is defined.
module cla_carry_sequencer #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [WIDTH-1:0] P,
    input  logic [WIDTH-1:0] G,
    input  logic             Cin,
    output logic [WIDTH:0]   C,
    output logic             Cout,
    output logic             BUSY,
    output logic             DONE,
    output logic             V
);

    localparam int NG = WIDTH / GROUP;
    localparam int CW = (NG > 1) ? $clog2(NG) : 1;

    if ((WIDTH % GROUP) != 0 || GROUP < 1) begin : g_bad_group
        $error("cla_carry_sequencer: WIDTH must be an integer multiple of GROUP");
    end

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] p_q, g_q;
    logic             gc_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH:0]   c_q;
    logic             busy_q, done_q;

    logic [GROUP-1:0] grp_p, grp_g, grp_c;
    logic [WIDTH:0]   c_d;
    logic             last_grp;

    assign last_grp = (cnt_q == CW'(NG - 1));

    always_comb begin
        logic t, acc;
        grp_p = '0;
        grp_g = '0;
        for (int k = 0; k < NG; k++)
            if (cnt_q == CW'(k)) begin
                grp_p = p_q[k*GROUP +: GROUP];
                grp_g = g_q[k*GROUP +: GROUP];
            end
        // Flattened sum-of-products per carry, so each bit is two logic levels from gc.
        for (int i = 0; i < GROUP; i++) begin
            acc = 1'b0;
            for (int k = 0; k <= i; k++) begin
                t = grp_g[k];
                for (int m = k + 1; m <= i; m++) t = t & grp_p[m];
                acc = acc | t;
            end
            t = gc_q;
            for (int m = 0; m <= i; m++) t = t & grp_p[m];
            grp_c[i] = acc | t;
        end
        c_d = c_q;
        for (int k = 0; k < NG; k++)
            if (cnt_q == CW'(k)) c_d[k*GROUP+1 +: GROUP] = grp_c;
    end

`ifdef CLA_CARRY_SEQUENCER_OVF_EN
    logic v_q;
    assign V = v_q;
`else
    assign V = 1'b0;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            p_q     <= '0;
            g_q     <= '0;
            gc_q    <= 1'b0;
            cnt_q   <= '0;
            c_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef CLA_CARRY_SEQUENCER_OVF_EN
            v_q     <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: if (START) begin
                    p_q     <= P;
                    g_q     <= G;
                    gc_q    <= Cin;
                    c_q     <= {{WIDTH{1'b0}}, Cin};
                    cnt_q   <= '0;
                    busy_q  <= 1'b1;
`ifdef CLA_CARRY_SEQUENCER_OVF_EN
                    v_q     <= 1'b0;
`endif
                    state_q <= S_RUN;
                end
                S_RUN: begin
                    c_q   <= c_d;
                    gc_q  <= grp_c[GROUP-1];
                    cnt_q <= cnt_q + CW'(1);
                    if (last_grp) begin
                        done_q  <= 1'b1;
`ifdef CLA_CARRY_SEQUENCER_OVF_EN
                        v_q     <= c_d[WIDTH] ^ c_d[WIDTH-1];
`endif
                        state_q <= S_FIN;
                    end
                end
                S_FIN: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign C    = c_q;
    assign Cout = c_q[WIDTH];
    assign BUSY = busy_q;
    assign DONE = done_q;

endmodule

// File: tb/tb_cla_carry_sequencer.sv
// Scoreboard bench for cla_carry_sequencer (WIDTH=16, GROUP=4): stimulus pushes expected
// carry vectors, a negedge monitor pops and compares on every DONE pulse.
module tb_cla_carry_sequencer;
    localparam int W = 16;

    logic         CLK = 1'b0, RST = 1'b1, START = 1'b0, Cin = 1'b0;
    logic [W-1:0] P = '0, G = '0;
    logic [W:0]   C;
    logic         Cout, BUSY, DONE, V;

    typedef struct {logic [W:0] c; logic v;} exp_t;
    exp_t exp_q[$];
    int   nvec = 0, nmis = 0, ndone = 0;

    cla_carry_sequencer #(.WIDTH(W), .GROUP(4)) dut (
        .CLK(CLK), .RST(RST), .START(START), .P(P), .G(G), .Cin(Cin),
        .C(C), .Cout(Cout), .BUSY(BUSY), .DONE(DONE), .V(V)
    );

    always #5 CLK = ~CLK;

`ifdef CLA_CARRY_SEQUENCER_OVF_EN
    localparam logic OVF_V = 1'b1;
`else
    localparam logic OVF_V = 1'b0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Monitor: every DONE pulse must match the oldest outstanding expectation.
    always @(negedge CLK) begin
        if (!RST && DONE === 1'b1) begin
            exp_t e;
            ndone++;
            if (exp_q.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
            else begin
                e = exp_q.pop_front();
                chk("C", 32'(C), 32'(e.c));
                chk("Cout", 32'(Cout), 32'(e.c[W]));
                chk("V", 32'(V), 32'(e.v));
                chk("BUSY_at_done", 32'(BUSY), 32'd1);
            end
        end
    end

    task automatic start_op(input logic [W-1:0] p, input logic [W-1:0] g, input logic ci,
                            input logic push, input logic [W:0] ec, input logic ev);
        exp_t e;
        @(negedge CLK);
        P = p; G = g; Cin = ci; START = 1'b1;
        if (push) begin e.c = ec; e.v = ev; exp_q.push_back(e); end
        @(negedge CLK);
        START = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (DONE !== 1'b1 && n < 20) begin @(negedge CLK); n++; end
        if (DONE !== 1'b1) chk("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (BUSY !== 1'b0 && n < 20) begin @(negedge CLK); n++; end
        if (BUSY !== 1'b0) chk("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_C"}, 32'(C), 32'd0);
        chk({tag, "_Cout"}, 32'(Cout), 32'd0);
        chk({tag, "_BUSY"}, 32'(BUSY), 32'd0);
        chk({tag, "_DONE"}, 32'(DONE), 32'd0);
        chk({tag, "_V"}, 32'(V), 32'd0);
    endtask

    initial begin
        int bcnt, dat, d0;
        #1 chk_zero("por");
        repeat (2) @(negedge CLK);
        RST = 1'b0;

        // Partial chain 0x00FF+0x0001: check BUSY length and DONE position.
        start_op(16'h00FF, 16'h0001, 1'b0, 1'b1, 17'h001FE, 1'b0);
        bcnt = 0; dat = 0;
        while (BUSY === 1'b1 && bcnt < 20) begin
            bcnt++;
            if (DONE === 1'b1) dat = bcnt;
            @(negedge CLK);
        end
        chk("busy_cycles", 32'(bcnt), 32'd5);
        chk("done_cycle", 32'(dat), 32'd5);
        chk("idle_holds_C", 32'(C), 32'h001FE);

        // Full ripple across every group boundary.
        start_op(16'hFFFF, 16'h0000, 1'b1, 1'b1, 17'h1FFFF, 1'b0);
        wait_done(); wait_idle();

        // Ignored START mid-RUN, then START held high across DONE.
        d0 = ndone;
        start_op(16'h0F0F, 16'h0101, 1'b0, 1'b1, 17'h01E1E, 1'b0);
        P = 16'hFFFF; G = 16'hFFFF; Cin = 1'b1; START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        @(negedge CLK);
        START = 1'b1;
        begin exp_t e; e.c = 17'h1FFFF; e.v = 1'b0; exp_q.push_back(e); end
        wait_done();
        @(negedge CLK);
        chk("held_gap_busy", 32'(BUSY), 32'd0);
        @(negedge CLK);
        chk("held_accept_busy", 32'(BUSY), 32'd1);
        START = 1'b0;
        wait_done(); wait_idle();
        chk("done_pulses", 32'(ndone - d0), 32'd2);

        // Reset in the second RUN cycle: everything clears at once, no DONE follows.
        d0 = ndone;
        start_op(16'h1234, 16'h0204, 1'b1, 1'b0, '0, 1'b0);
        @(posedge CLK);
        #2 RST = 1'b1;
        #1 chk_zero("rst_run");
        @(negedge CLK);
        RST = 1'b0;
        repeat (8) @(negedge CLK);
        chk("rst_no_done", 32'(ndone - d0), 32'd0);

        // Overflow 0x7FFF+0x0001 completes normally after the reset.
        start_op(16'h7FFF, 16'h0001, 1'b0, 1'b1, 17'h0FFFE, OVF_V);
        wait_done(); wait_idle();
        chk("idle_V", 32'(V), 32'(OVF_V));

        // Async reset mid-clock with random inputs, no clock edge needed.
        @(negedge CLK);
        P = 16'($urandom); G = 16'($urandom) & P; Cin = 1'($urandom); START = 1'b1;
        @(posedge CLK);
        #2 RST = 1'b1;
        #1 chk_zero("rst_async");
        START = 1'b0;
        @(negedge CLK);
        RST = 1'b0;
        repeat (3) @(negedge CLK);

        chk("pending", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/cla_carry_sequencer.md
Name: cla_carry_sequencer

Overview:
- Consumer side of the partial-full-adder (PFA) row. Takes per-bit propagate P and generate G from WIDTH PFA slices, plus a word carry-in.
- Resolves the carry into every bit with group lookahead, one GROUP-bit group per clock.
- Returns the registered carry vector to the PFA Cin inputs, with a start/busy/done handshake.
- Replaces a full combinational lookahead tree with a small multi-cycle unit.

Parameters:
- WIDTH, 16, number of PFA slices (operand bits).
- GROUP, 4, bits resolved per cycle; WIDTH must be an integer multiple of GROUP; elaboration fails otherwise.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  asynchronous, active-high reset.
- START  input  1  request; sampled only in IDLE.
- P  input  WIDTH  per-bit propagate (A|B) from PFA row.
- G  input  WIDTH  per-bit generate (A&B) from PFA row.
- Cin  input  1  word carry-in.
- C  output  WIDTH+1  C[i] = carry into bit i; C[0]=Cin; C[WIDTH]=carry-out.
- Cout  output  1  equals C[WIDTH].
- BUSY  output  1  operation in progress.
- DONE  output  1  one-cycle pulse, C valid.
- V  output  1  signed overflow (see Optional Feature).

Behaviour:
- Reset (async, any time, including mid-operation): state=IDLE, C=0, Cout=0, BUSY=0, DONE=0, V=0, group counter=0, internal P/G/Cin snapshot=0. The operation in progress is discarded.
- NG = WIDTH/GROUP. Counter width = clog2(NG), minimum 1.
- FSM states: IDLE, RUN, FIN.
- IDLE:
  - On a rising edge with START=1: snapshot P, G, Cin; C <= {WIDTH'b0, Cin}; group carry gc <= Cin; counter <= 0; go to RUN; BUSY=1 from that edge.
  - With START=0: remain in IDLE; C holds its last result.
- RUN, each edge, for group k = counter, bits j = k*GROUP .. k*GROUP+GROUP-1:
  - c(j+1) = G[j] | (P[j] & c(j)), with c(k*GROUP) = gc, computed in lookahead (flattened) form within the group.
  - Write C[j+1] for all j in the group.
  - gc <= c(k*GROUP+GROUP); counter <= counter+1.
  - After group NG-1 is written, go to FIN.
- FIN: DONE=1 and BUSY=1 for exactly this one cycle; C, Cout and V are final and remain stable until the next accepted START. Next edge returns to IDLE.
- Latency: START accepted at edge 0; groups are resolved at edges 1..NG; DONE is high in the cycle after edge NG. Total BUSY time is NG+1 cycles.
- START while BUSY=1 (RUN or FIN) is ignored; there is no queueing. Changes to P/G/Cin after acceptance do not affect the result.
- START held high continuously: a new operation is accepted on the first IDLE edge, one cycle after DONE.
- Bits of C above the current group are 0 while RUN is in progress; consumers use C only when DONE=1 or when idle.
- Cout is combinationally equal to C[WIDTH].

Optional Feature:
- Macro: CLA_CARRY_SEQUENCER_OVF_EN.
- Defined: V = C[WIDTH] ^ C[WIDTH-1], i.e. two's-complement overflow. V is registered and updated at the same edge as the last group; it is 0 during RUN and after reset.
- Undefined: the V port exists but is tied to constant 0, and no overflow logic is built.

Test Plan (WIDTH=16, GROUP=4):
- Reset: assert RST mid-clock with random inputs -> C=0x00000, Cout=0, BUSY=0, DONE=0, V=0 immediately, without waiting for a clock edge.
- Partial carry chain: A=0x00FF, B=0x0001, so P=0x00FF, G=0x0001, Cin=0; START one cycle -> DONE high in the cycle after the 4th edge post-acceptance; C=0x001FE, Cout=0; BUSY high for 5 cycles.
- Full ripple: P=0xFFFF, G=0x0000, Cin=1 -> C=0x1FFFF, Cout=1; the carry crosses all 4 group boundaries.
- Handshake: START again 2 cycles after acceptance with different P/G -> ignored; result matches the first snapshot; a single DONE pulse. Then START held high -> second operation accepted one cycle after DONE.
- Reset mid-RUN: RST at cycle 2 of RUN -> IDLE, all outputs 0, no DONE pulse. A new START afterwards completes normally.
- Overflow (macro defined): A=0x7FFF, B=0x0001, so P=0x7FFF, G=0x0001, Cin=0 -> C[15]=1, C[16]=0, V=1. With the macro undefined -> V=0.
